// File: rtl/bp_be_stride_prefetch_engine.sv
//------------------------------------------------------------------------------
// Module   : bp_be_stride_prefetch_engine
// Purpose  : Expands stride-discovery events into prefetch address streams for
//            the D$ prefetch port. One active stream plus a one-deep pending slot.
//            Optional macro: BP_BE_PREFETCH_PAGE_CROSS_EN (disables page check).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_be_stride_prefetch_engine #(
  parameter int vaddr_width_p          = 39,
  parameter int stride_width_p         = 8,
  parameter int effective_addr_width_p = vaddr_width_p,
  parameter int degree_p               = 4,
  parameter int page_offset_width_p    = 12
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_discovery_i,
  input  logic                              confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]          striding_pc_i,
  input  logic [effective_addr_width_p-1:0] eff_addr_i,
  input  logic [stride_width_p-1:0]         stride_i,
  input  logic                              flush_i,
  output logic                              pf_v_o,
  output logic [effective_addr_width_p-1:0] pf_addr_o,
  input  logic                              pf_ready_i,
  output logic                              busy_o,
  output logic                              dropped_o
);

  localparam int cnt_width_lp = $clog2(degree_p + 1);
  localparam int ext_width_lp = effective_addr_width_p - stride_width_p;

  localparam logic [0:0] e_idle  = 1'b0;
  localparam logic [0:0] e_issue = 1'b1;

  logic [0:0]                        state_q, state_d;
  logic [effective_addr_width_p-1:0] cur_q, cur_d;
  logic [stride_width_p-1:0]         stride_q, stride_d;
  logic [vaddr_width_p-1:0]          pc_q, pc_d;
  logic [cnt_width_lp-1:0]           cnt_q, cnt_d;

  logic                              pend_v_q, pend_v_d;
  logic [effective_addr_width_p-1:0] pend_eff_q, pend_eff_d;
  logic [stride_width_p-1:0]         pend_stride_q, pend_stride_d;
  logic [vaddr_width_p-1:0]          pend_pc_q, pend_pc_d;
  logic                              pend_conf_q, pend_conf_d;

  logic                              dropped_q, dropped_d;

  logic                              ev_v, page_ok, hs, term, last;
  logic                              load, sel_pend;
  logic [effective_addr_width_p-1:0] load_eff, load_stride_ext, stride_q_ext;
  logic [stride_width_p-1:0]         load_stride;
  logic [vaddr_width_p-1:0]          load_pc;
  logic                              load_conf;

  assign ev_v = (start_discovery_i | confirm_discovery_i) & (stride_i != '0);

  assign load_eff    = sel_pend ? pend_eff_q    : eff_addr_i;
  assign load_stride = sel_pend ? pend_stride_q : stride_i;
  assign load_pc     = sel_pend ? pend_pc_q     : striding_pc_i;
  assign load_conf   = sel_pend ? pend_conf_q   : confirm_discovery_i;

  assign load_stride_ext = {{ext_width_lp{load_stride[stride_width_p-1]}}, load_stride};
  assign stride_q_ext    = {{ext_width_lp{stride_q[stride_width_p-1]}}, stride_q};

`ifndef BP_BE_PREFETCH_PAGE_CROSS_EN
  // Only the page number of the stream's base address is needed for the check.
  logic [vaddr_width_p-1:page_offset_width_p] base_q, base_d;

  assign base_d  = load ? load_eff[vaddr_width_p-1:page_offset_width_p] : base_q;
  assign page_ok = (cur_q[vaddr_width_p-1:page_offset_width_p] == base_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) base_q <= '0;
    else         base_q <= base_d;
  end
`else
  assign page_ok = 1'b1;
`endif

  assign pf_v_o    = (state_q == e_issue) & page_ok;
  assign pf_addr_o = cur_q;
  assign busy_o    = (state_q == e_issue) | pend_v_q;
  assign dropped_o = dropped_q;

  assign hs   = pf_v_o & pf_ready_i;
  assign term = (state_q == e_issue) & ~page_ok;
  assign last = hs & (cnt_q == cnt_width_lp'(1));

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    stride_d      = stride_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    pend_v_d      = pend_v_q;
    pend_eff_d    = pend_eff_q;
    pend_stride_d = pend_stride_q;
    pend_pc_d     = pend_pc_q;
    pend_conf_d   = pend_conf_q;
    dropped_d     = 1'b0;
    load          = 1'b0;
    sel_pend      = 1'b0;

    case (state_q)
      e_idle: begin
        if (ev_v) load = 1'b1;
      end
      default: begin
        if (pend_v_q && (hs || term)) begin
          // Pending event preempts; the slot frees up so a new event fills it without a drop.
          load     = 1'b1;
          sel_pend = 1'b1;
          pend_v_d = 1'b0;
          if (ev_v && (striding_pc_i != pc_q)) begin
            pend_v_d      = 1'b1;
            pend_eff_d    = eff_addr_i;
            pend_stride_d = stride_i;
            pend_pc_d     = striding_pc_i;
            pend_conf_d   = confirm_discovery_i;
          end
        end else if (last || term) begin
          if (ev_v) load    = 1'b1;
          else      state_d = e_idle;
        end else begin
          if (hs) begin
            cnt_d = cnt_q - cnt_width_lp'(1);
            cur_d = cur_q + stride_q_ext;
          end
          if (ev_v && (striding_pc_i != pc_q)) begin
            pend_v_d      = 1'b1;
            pend_eff_d    = eff_addr_i;
            pend_stride_d = stride_i;
            pend_pc_d     = striding_pc_i;
            pend_conf_d   = confirm_discovery_i;
            dropped_d     = pend_v_q;
          end
        end
      end
    endcase

    if (load) begin
      state_d  = e_issue;
      cur_d    = load_eff + load_stride_ext;
      stride_d = load_stride;
      pc_d     = load_pc;
      cnt_d    = load_conf ? cnt_width_lp'(degree_p) : cnt_width_lp'(1);
    end

    if (flush_i) begin
      state_d   = e_idle;
      pend_v_d  = 1'b0;
      dropped_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= e_idle;
      cur_q         <= '0;
      stride_q      <= '0;
      pc_q          <= '0;
      cnt_q         <= '0;
      pend_v_q      <= 1'b0;
      pend_eff_q    <= '0;
      pend_stride_q <= '0;
      pend_pc_q     <= '0;
      pend_conf_q   <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      stride_q      <= stride_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      pend_v_q      <= pend_v_d;
      pend_eff_q    <= pend_eff_d;
      pend_stride_q <= pend_stride_d;
      pend_pc_q     <= pend_pc_d;
      pend_conf_q   <= pend_conf_d;
      dropped_q     <= dropped_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_be_stride_prefetch_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_bp_be_stride_prefetch_engine
// Purpose  : Scoreboard bench for bp_be_stride_prefetch_engine; expected
//            prefetch addresses are queued at stimulus and popped on handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_be_stride_prefetch_engine;

  localparam int VA = 39;
  localparam int SW = 8;
  localparam int PO = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, confirm_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
  logic [VA-1:0] pc_i = '0, eff_i = '0;
  logic [SW-1:0] stride_i = '0;
  logic          pf_v, busy, dropped;
  logic [VA-1:0] pf_addr;

  int n_checks = 0;
  int n_errors = 0;
  logic [VA-1:0] sb[$];

  bp_be_stride_prefetch_engine #(
    .vaddr_width_p(VA), .stride_width_p(SW), .effective_addr_width_p(VA),
    .degree_p(4), .page_offset_width_p(PO)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .start_discovery_i(start_i), .confirm_discovery_i(confirm_i),
    .striding_pc_i(pc_i), .eff_addr_i(eff_i), .stride_i(stride_i),
    .flush_i(flush_i),
    .pf_v_o(pf_v), .pf_addr_o(pf_addr), .pf_ready_i(ready_i),
    .busy_o(busy), .dropped_o(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference stream: addresses eff+k*stride, truncated at the first page change
  // unless page crossing is enabled; at most n entries are queued.
  function automatic int push_stream(input logic [VA-1:0] eff, input logic [SW-1:0] st,
                                     input int n);
    logic [VA-1:0] a, sx;
    int pushed;
    sx = {{(VA-SW){st[SW-1]}}, st};
    a = eff;
    pushed = 0;
    for (int k = 0; k < n; k++) begin
      a = a + sx;
`ifndef BP_BE_PREFETCH_PAGE_CROSS_EN
      if (a[VA-1:PO] != eff[VA-1:PO]) break;
`endif
      sb.push_back(a);
      pushed++;
    end
    return pushed;
  endfunction

  always @(negedge clk) begin
    if (!rst && pf_v && ready_i) begin
      if (sb.size() == 0) check("sb_extra", 64'(sb.size()), 64'd1);
      else                check("sb_addr", 64'(pf_addr), 64'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ev(input logic s, input logic c, input logic [VA-1:0] pc,
                    input logic [VA-1:0] eff, input logic [SW-1:0] st);
    start_i = s; confirm_i = c; pc_i = pc; eff_i = eff; stride_i = st;
    step();
    start_i = 1'b0; confirm_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || pf_v) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 64'(n), 64'd0);
    step();
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    #2;
    check("rst_v", 64'(pf_v), 64'd0);
    check("rst_addr", 64'(pf_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(dropped), 64'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Confirm stream, ready held high: four prefetches then idle at t+5.
    ready_i = 1'b1;
    n = push_stream(39'h1000, 8'h08, 4);
    ev(1'b0, 1'b1, 39'h100, 39'h1000, 8'h08);
    @(negedge clk); check("cs_v_t1", 64'(pf_v), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk); check("cs_v_t5", 64'(pf_v), 64'd0);
    check("cs_sb", 64'(sb.size()), 64'd0);
    step();

    // Start event, negative stride: single prefetch unless it leaves the page.
    n = push_stream(39'h2000, 8'hF0, 1);
    ev(1'b1, 1'b0, 39'h104, 39'h2000, 8'hF0);
    @(negedge clk); check("neg_v_t1", 64'(pf_v), 64'(n > 0));
    step();
    @(negedge clk); check("neg_v_t2", 64'(pf_v), 64'd0);
    check("neg_busy", 64'(busy), 64'd0);
    step();

    // Backpressure on the second prefetch.
    n = push_stream(39'h1000, 8'h08, 4);
    ev(1'b0, 1'b1, 39'h108, 39'h1000, 8'h08);
    step();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_v", 64'(pf_v), 64'd1);
      check("bp_addr", 64'(pf_addr), 64'h1010);
      step();
    end
    ready_i = 1'b1;
    wait_idle("bp");

    // Page cross.
    n = push_stream(39'h0FF0, 8'h08, 4);
    ev(1'b0, 1'b1, 39'h10C, 39'h0FF0, 8'h08);
    wait_idle("pg");

    // Pending overwrite: A then B queued behind a stalled stream.
    ready_i = 1'b0;
    sb.push_back(39'h1008);
    ev(1'b0, 1'b1, 39'h110, 39'h1000, 8'h08);
    ev(1'b0, 1'b1, 39'hA00, 39'h5000, 8'h04);
    check("po_drop_a", 64'(dropped), 64'd0);
    check("po_busy", 64'(busy), 64'd1);
    ev(1'b0, 1'b1, 39'hB00, 39'h3000, 8'h04);
    check("po_drop_b", 64'(dropped), 64'd1);
    step();
    check("po_drop_once", 64'(dropped), 64'd0);
    n = push_stream(39'h3000, 8'h04, 4);
    ready_i = 1'b1;
    wait_idle("po");

    // Event with the active stream's PC is ignored.
    ready_i = 1'b0;
    n = push_stream(39'h6000, 8'h10, 4);
    ev(1'b0, 1'b1, 39'h120, 39'h6000, 8'h10);
    ev(1'b0, 1'b1, 39'h120, 39'h7000, 8'h10);
    check("spc_drop", 64'(dropped), 64'd0);
    ready_i = 1'b1;
    wait_idle("spc");

    // Zero stride is not an event.
    ev(1'b0, 1'b1, 39'h124, 39'hD000, 8'h00);
    @(negedge clk);
    check("zs_busy", 64'(busy), 64'd0);
    check("zs_v", 64'(pf_v), 64'd0);
    step();

    // Event on the final handshake with an empty slot loads directly.
    n = push_stream(39'h8000, 8'h08, 1);
    ev(1'b1, 1'b0, 39'h130, 39'h8000, 8'h08);
    n = push_stream(39'h9000, 8'h08, 1);
    ev(1'b1, 1'b0, 39'h134, 39'h9000, 8'h08);
    @(negedge clk); check("dl_v", 64'(pf_v), 64'd1);
    wait_idle("dl");

    // Flush mid-stream with a pending event.
    ready_i = 1'b0;
    ev(1'b0, 1'b1, 39'h140, 39'hA000, 8'h08);
    ev(1'b0, 1'b1, 39'h144, 39'hA100, 8'h08);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fl_v", 64'(pf_v), 64'd0);
    check("fl_busy", 64'(busy), 64'd0);
    ready_i = 1'b1;
    repeat (5) step();
    check("fl_sb", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-stream.
    ready_i = 1'b0;
    ev(1'b0, 1'b1, 39'h150, 39'hB000, 8'h08);
    check("ar_pre_v", 64'(pf_v), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_v", 64'(pf_v), 64'd0);
    check("ar_addr", 64'(pf_addr), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    step();
    ready_i = 1'b1;
    n = push_stream(39'hC000, 8'h20, 4);
    ev(1'b0, 1'b1, 39'h154, 39'hC000, 8'h20);
    wait_idle("ar_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t expected <200000", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
